adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
// Sequences the MAX10 hard-ADC wrapper in a round-robin scan of enabled channels. Drives chsel/soc/tsen,
// waits for eoc, captures dout and presents each sample with its channel tag on a valid/ready stream.
// Sits between the ADC wrapper and the display/temperature-conversion logic; all logic on pll_clk.
// PARAMETERS
// SETTLE_CYC   8      cycles chsel (and tsen) held stable before soc rises
// TIMEOUT_CYC  4095   max cycles soc may stay high without eoc before abort
// TSD_CH       17     channel index that is the temperature-sensor diode (tsen asserted)
// PORTS
// pll_clk      in   1   clock (same clock feeding the ADC wrapper)
// rst_n        in   1   synchronous reset, active-low
// enable       in   1   level: run continuous scan while high
// ch_mask      in   32  bit i = scan channel i (only bits 0..31 valid); latched at each scan start
// clr          in   1   pulse: clears sticky overrun
// adc_chsel    out  5   to wrapper chsel
// adc_soc      out  1   to wrapper soc
// adc_tsen     out  1   to wrapper tsen
// adc_dout     in   12  from wrapper dout
// adc_eoc      in   1   from wrapper eoc (treated asynchronous)
// s_valid      out  1   sample available
// s_ready      in   1   consumer accepts sample
// s_data       out  12  sample value
// s_chan       out  5   channel the sample came from
// busy         out  1   high in any state but IDLE
// overrun      out  1   sticky: a sample was dropped because the output register was full
// timeout_err  out  1   one-cycle pulse: conversion aborted on timeout
// BEHAVIOUR
// - Reset (rst_n=0 at pll_clk edge): state IDLE; adc_chsel=0, adc_soc=0, adc_tsen=0, s_valid=0,
//   s_data=0, s_chan=0, busy=0, overrun=0, timeout_err=0; latched mask=0; settle/timeout counters=0.
//   Reset mid-conversion drops soc the next edge; the in-flight result is discarded.
// - eoc goes through a 2-FF synchroniser + rising-edge detect (eoc_rise), 3 cycles latency from adc_eoc.
// - FSM: IDLE -> SETTLE -> CONVERT -> CAPTURE -> SETTLE|IDLE.
//   IDLE: if enable && ch_mask!=0: latch mask, pick lowest set bit, drive adc_chsel, go SETTLE.
//     enable && ch_mask==0: remain IDLE.
//   SETTLE: adc_tsen = (adc_chsel==TSD_CH); count SETTLE_CYC cycles, then adc_soc=1, go CONVERT.
//   CONVERT: soc held high; chsel/tsen stable. On eoc_rise: soc=0, go CAPTURE.
//     If TIMEOUT_CYC cycles pass without eoc_rise: soc=0, timeout_err pulse, no sample, advance channel.
//   CAPTURE: register adc_dout into the output register (see below); advance channel.
// - Advance: next set bit above current index in latched mask, wrapping 31->0. On wrap, or if enable=0,
//   end of scan: enable=1 relatches ch_mask and restarts at its lowest set bit (SETTLE); enable=0 -> IDLE.
//   Single-bit mask repeats the same channel. enable falling mid-conversion never aborts: finish CONVERT.
// - Output register (1 deep): s_valid rises the cycle after CAPTURE; s_data/s_chan stable while
//   s_valid && !s_ready. Transfer when s_valid && s_ready. CAPTURE with s_valid=1 and s_ready=0: new
//   sample dropped, overrun set. Capture and accept in the same cycle: register loads the new sample,
//   s_valid stays 1, no overrun. clr and an overrun event in the same cycle: overrun stays 1.
// - Throughput per channel: SETTLE_CYC + 1 + ADC conversion + 3 (sync) + 1 cycles.
// STRUCTURE
// - adc_seq_pkg: state_t enum {IDLE,SETTLE,CONVERT,CAPTURE}; ADC_DW=12; CH_W=5; CH_N=32.
// - Sub-module adc_eoc_sync: 2-FF synchroniser + rising-edge detect, rst_n synchronous.
// - Next-channel priority search (rotate mask, find first one) stays inline in this module as a function.
// TESTING (bench uses a behavioural ADC model: eoc pulse N cycles after soc, dout=channel*100)
// - mask=32'h0000_0007, enable=1, s_ready=1 -> samples ch0,1,2,0,... with s_data 0,100,200,0;
//   soc low >= SETTLE_CYC cycles after each chsel change.
// - mask bit 17 only -> adc_tsen=1 for the whole SETTLE+CONVERT window; s_chan=17, s_data=1700 repeated.
// - model never pulses eoc -> soc drops after exactly TIMEOUT_CYC cycles, one timeout_err pulse,
//   s_valid stays 0, next channel selected.
// - s_ready=0 for two conversions -> first sample held stable, overrun=1, second sample lost;
//   clr pulse -> overrun=0.
// - enable dropped mid-CONVERT -> soc held until eoc, sample delivered, then IDLE, busy=0.
// - rst_n=0 during CONVERT -> next edge: soc=0, s_valid=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and widths for the ADC scan sequencer.
//   state_t : sequencer FSM states
//   ADC_DW  : ADC sample width
//   CH_W    : channel index width
//   CH_N    : number of scannable channels
package adc_seq_pkg;

    localparam int ADC_DW = 12;
    localparam int CH_W   = 5;
    localparam int CH_N   = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT,
        CAPTURE
    } state_t;

endpackage

// File: rtl/adc_eoc_sync.sv
// Brings the ADC end-of-conversion flag into the pll_clk domain and turns
// its rising edge into a single-cycle pulse.
//   clk      in  : sampling clock
//   rst_n    in  : synchronous reset, active-low
//   eoc      in  : end-of-conversion from the ADC wrapper (asynchronous)
//   eoc_rise out : one-cycle pulse on a synchronised rising edge of eoc
module adc_eoc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic eoc,
    output logic eoc_rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= eoc;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // eoc rising before edge N is acted on by the FSM at edge N+2.
    assign eoc_rise = sync & ~sync_d;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin scanner for the MAX10 hard-ADC wrapper. Selects each enabled
// channel in turn, lets the mux settle, starts a conversion, waits for eoc and
// hands the result plus its channel tag to a 1-deep valid/ready output stage.
//
// Ports
//   pll_clk     in  : clock shared with the ADC wrapper
//   rst_n       in  : synchronous reset, active-low
//   enable      in  : run continuous scans while high
//   ch_mask     in  : channel enable bits, latched at every scan start
//   clr         in  : clears the sticky overrun flag
//   adc_chsel   out : channel select to wrapper
//   adc_soc     out : start of conversion to wrapper
//   adc_tsen    out : temperature-sensor enable to wrapper
//   adc_dout    in  : conversion result from wrapper
//   adc_eoc     in  : end of conversion from wrapper (asynchronous)
//   s_valid     out : sample available
//   s_ready     in  : consumer accepts sample
//   s_data      out : sample value
//   s_chan      out : channel the sample came from
//   busy        out : sequencer not idle
//   overrun     out : sticky, a sample was dropped on a full output register
//   timeout_err out : one-cycle pulse when a conversion is abandoned
//
// state   | meaning
// IDLE    | waiting for enable with a non-empty mask
// SETTLE  | chsel/tsen driven, counting down mux settling time
// CONVERT | soc high, waiting for eoc or the timeout
// CAPTURE | latch adc_dout into the output register, pick next channel
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 4095,
    parameter int TSD_CH      = 17
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CH_N-1:0]   ch_mask,
    input  logic              clr,
    output logic [CH_W-1:0]   adc_chsel,
    output logic              adc_soc,
    output logic              adc_tsen,
    input  logic [ADC_DW-1:0] adc_dout,
    input  logic              adc_eoc,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [ADC_DW-1:0] s_data,
    output logic [CH_W-1:0]   s_chan,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [CH_W-1:0]  TSD_SEL    = CH_W'(TSD_CH);

    // Lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [CH_W-1:0] lowest_set(input logic [CH_N-1:0] m);
        lowest_set = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CH_W'(i);
        end
    endfunction

    // {found, index} of the lowest set bit strictly above cur; found=0 means
    // the scan has wrapped and this pass is complete.
    function automatic logic [CH_W:0] next_above(input logic [CH_N-1:0] m,
                                                 input logic [CH_W-1:0] cur);
        next_above = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_above = {1'b1, CH_W'(i)};
        end
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   chsel_q;
    logic [CH_W-1:0]   chsel_nxt;
    logic [CH_N-1:0]   mask_q;
    logic [CH_N-1:0]   mask_nxt;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  tmr_nxt;
    logic              tmo_q;
    logic              tmo_nxt;
    logic              advance;
    logic              eoc_rise;
    logic [CH_W:0]     nxt_hit;
    logic [CH_W-1:0]   first_ch;
    logic              valid_q;
    logic [ADC_DW-1:0] data_q;
    logic [CH_W-1:0]   chan_q;
    logic              ovr_q;
    logic              drop;

    adc_eoc_sync u_eoc_sync (
        .clk      (pll_clk),
        .rst_n    (rst_n),
        .eoc      (adc_eoc),
        .eoc_rise (eoc_rise)
    );

    assign nxt_hit  = next_above(mask_q, chsel_q);
    assign first_ch = lowest_set(ch_mask);

    always_ff @(posedge pll_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        chsel_nxt = chsel_q;
        mask_nxt  = mask_q;
        tmr_nxt   = tmr_q;
        tmo_nxt   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    mask_nxt  = ch_mask;
                    chsel_nxt = first_ch;
                    tmr_nxt   = SETTLE_LD;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_nxt   = TIMEOUT_LD;
                    state_nxt = CONVERT;
                end else begin
                    tmr_nxt = tmr_q - TMR_ONE;
                end
            end
            CONVERT: begin
                if (eoc_rise) begin
                    state_nxt = CAPTURE;
                end else if (tmr_q == '0) begin
                    tmo_nxt = 1'b1;
                    advance = 1'b1;
                end else begin
                    tmr_nxt = tmr_q - TMR_ONE;
                end
            end
            CAPTURE: advance = 1'b1;
            default: state_nxt = IDLE;
        endcase

        // A wrap or a dropped enable ends the pass; a still-enabled scan
        // restarts from a freshly latched mask.
        if (advance) begin
            if (enable && nxt_hit[CH_W]) begin
                chsel_nxt = nxt_hit[CH_W-1:0];
                tmr_nxt   = SETTLE_LD;
                state_nxt = SETTLE;
            end else if (enable && (ch_mask != '0)) begin
                mask_nxt  = ch_mask;
                chsel_nxt = first_ch;
                tmr_nxt   = SETTLE_LD;
                state_nxt = SETTLE;
            end else begin
                tmr_nxt   = '0;
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        adc_soc  = 1'b0;
        adc_tsen = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            SETTLE:  adc_tsen = (chsel_q == TSD_SEL);
            CONVERT: begin
                adc_soc  = 1'b1;
                adc_tsen = (chsel_q == TSD_SEL);
            end
            CAPTURE: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // A capture into a full register that is not being drained is lost.
    assign drop = (state == CAPTURE) && valid_q && !s_ready;

    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            chsel_q <= '0;
            mask_q  <= '0;
            tmr_q   <= '0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            chsel_q <= chsel_nxt;
            mask_q  <= mask_nxt;
            tmr_q   <= tmr_nxt;
            tmo_q   <= tmo_nxt;

            if (state == CAPTURE) begin
                if (!valid_q || s_ready) begin
                    valid_q <= 1'b1;
                    data_q  <= adc_dout;
                    chan_q  <= chsel_q;
                end
            end else if (valid_q && s_ready) begin
                valid_q <= 1'b0;
            end

            // Setting wins over clr so a simultaneous drop is never lost.
            if (drop)     ovr_q <= 1'b1;
            else if (clr) ovr_q <= 1'b0;
        end
    end

    assign adc_chsel   = chsel_q;
    assign s_valid     = valid_q;
    assign s_data      = data_q;
    assign s_chan      = chan_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural ADC (eoc N cycles after soc,
// dout = channel*100) plus a scoreboard predicting the round-robin order.
module tb_adc_scan_sequencer;

    localparam int SETTLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 4095;
    localparam int TSD_CH      = 17;

    logic        pll_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic [31:0] ch_mask = '0;
    logic        clr     = 1'b0;
    logic [4:0]  adc_chsel;
    logic        adc_soc;
    logic        adc_tsen;
    logic [11:0] adc_dout = '0;
    logic        adc_eoc  = 1'b0;
    logic        s_valid;
    logic        s_ready  = 1'b0;
    logic [11:0] s_data;
    logic [4:0]  s_chan;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pll_clk = ~pll_clk;

    adc_scan_sequencer #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TSD_CH      (TSD_CH)
    ) dut (
        .pll_clk     (pll_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .clr         (clr),
        .adc_chsel   (adc_chsel),
        .adc_soc     (adc_soc),
        .adc_tsen    (adc_tsen),
        .adc_dout    (adc_dout),
        .adc_eoc     (adc_eoc),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_chan      (s_chan),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round-robin rule: next enabled channel above the last one, else wrap.
    function automatic int next_ch(input logic [31:0] m, input int last);
        for (int i = last + 1; i < 32; i++) if (m[i]) return i;
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Behavioural ADC.
    int conv_n  = 5;
    bit eoc_off = 0;
    int soc_age = 0;
    always @(posedge pll_clk) begin
        #1;
        if (adc_soc && rst_n) begin
            soc_age++;
            if (!eoc_off && soc_age >= conv_n) begin
                if (!adc_eoc) adc_dout = 12'(int'(adc_chsel) * 100);
                adc_eoc = 1'b1;
            end
        end else begin
            soc_age = 0;
            adc_eoc = 1'b0;
        end
    end

    // Consumer: either a fixed level or random stalls no longer than 3 cycles.
    bit rnd_ready = 0;
    bit ready_cmd = 0;
    int low_run   = 0;
    always @(posedge pll_clk) begin
        #2;
        if (rnd_ready) begin
            if (low_run >= 3 || $urandom_range(1, 0) == 1) begin
                s_ready = 1'b1;
                low_run = 0;
            end else begin
                s_ready = 1'b0;
                low_run++;
            end
        end else begin
            s_ready = ready_cmd;
        end
    end

    // Monitor and scoreboard.
    bit          sb_on      = 0;
    logic [31:0] sb_mask    = '0;
    int          conv_last  = -1;
    int          smp_last   = -1;
    int          n_smp      = 0;
    int          n_xfer     = 0;
    int          last_chan  = -1;
    int          last_data  = -1;
    int          tmo_pulses = 0;
    int          settle_run = 0;
    int          tsen_run   = 0;
    logic        soc_d      = 1'b0;
    logic [4:0]  chsel_d    = '0;

    always @(negedge pll_clk) begin
        if (timeout_err) tmo_pulses++;
        if (s_valid && s_ready) begin
            n_xfer++;
            last_chan = int'(s_chan);
            last_data = int'(s_data);
        end
        if (sb_on) begin
            if (adc_soc && !soc_d) begin
                conv_last = next_ch(sb_mask, conv_last);
                chk("conv_chsel", adc_chsel, conv_last);
                chk("settle_len", settle_run >= SETTLE_CYC, 1);
                if (adc_chsel == 5'(TSD_CH)) chk("tsen_settle", tsen_run >= SETTLE_CYC, 1);
                else                         chk("tsen_off", tsen_run, 0);
            end
            if (adc_soc) chk("tsen_conv", adc_tsen, adc_chsel == 5'(TSD_CH));
            if (s_valid && s_ready) begin
                smp_last = next_ch(sb_mask, smp_last);
                chk("s_chan", s_chan, smp_last);
                chk("s_data", s_data, smp_last * 100);
                n_smp++;
            end
        end
        if (busy && !adc_soc) settle_run = (adc_chsel == chsel_d) ? settle_run + 1 : 1;
        else                  settle_run = 0;
        tsen_run = adc_tsen ? tsen_run + 1 : 0;
        soc_d    = adc_soc;
        chsel_d  = adc_chsel;
    end

    task automatic wait_idle();
        int b = 0;
        while ((busy || s_valid) && b < 6000) begin
            @(negedge pll_clk);
            b++;
        end
        chk("idle_busy", busy, 0);
    endtask

    task automatic run_scan(input logic [31:0] m, input int nsamp);
        int start = n_smp;
        int b = 0;
        sb_mask   = m;
        conv_last = -1;
        smp_last  = -1;
        sb_on     = 1;
        ch_mask   = m;
        enable    = 1'b1;
        while ((n_smp - start) < nsamp && b < 8000) begin
            @(negedge pll_clk);
            b++;
        end
        chk("scan_samples", (n_smp - start) >= nsamp, 1);
        enable = 1'b0;
        wait_idle();
        sb_on = 0;
    endtask

    task automatic wait_soc_high();
        int b = 0;
        while (!adc_soc && b < 300) begin
            @(negedge pll_clk);
            b++;
        end
        chk("soc_rise", adc_soc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m;
        int cnt;
        int base;
        int x0;
        int b;

        repeat (3) @(posedge pll_clk);
        @(negedge pll_clk);
        chk("rst_chsel", adc_chsel, 0);
        chk("rst_soc", adc_soc, 0);
        chk("rst_tsen", adc_tsen, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_chan", s_chan, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_tmo", timeout_err, 0);
        rst_n = 1'b1;

        // Enabled with an empty mask stays idle.
        ready_cmd = 1;
        enable = 1'b1;
        repeat (12) @(negedge pll_clk);
        chk("empty_mask_busy", busy, 0);
        chk("empty_mask_soc", adc_soc, 0);
        enable = 1'b0;

        conv_n = 5;
        run_scan(32'h0000_0007, 7);
        run_scan(32'h1 << TSD_CH, 3);

        // Randomised masks, conversion times and consumer stalls.
        rnd_ready = 1;
        for (int k = 0; k < 6; k++) begin
            m = $urandom & $urandom & $urandom;
            if (m == '0) m[$urandom_range(31, 0)] = 1'b1;
            conv_n = $urandom_range(12, 2);
            run_scan(m, 2 * $countones(m) + 1);
        end
        rnd_ready = 0;
        repeat (4) @(negedge pll_clk);
        chk("no_overrun", overrun, 0);

        // Conversion that never completes.
        eoc_off = 1;
        ch_mask = 32'h5;
        base = tmo_pulses;
        x0 = n_xfer;
        enable = 1'b1;
        wait_soc_high();
        cnt = 0;
        while (adc_soc && cnt < 5000) begin
            cnt++;
            @(negedge pll_clk);
        end
        chk("tmo_soc_len", cnt, TIMEOUT_CYC);
        chk("tmo_pulse_now", timeout_err, 1);
        chk("tmo_next_ch", adc_chsel, 2);
        chk("tmo_no_valid", s_valid, 0);
        eoc_off = 0;
        enable = 1'b0;
        wait_idle();
        chk("tmo_pulse_cnt", tmo_pulses - base, 1);
        chk("tmo_xfers", n_xfer - x0, 1);
        chk("tmo_last_chan", last_chan, 2);
        chk("tmo_last_data", last_data, 200);

        // Backpressure: first sample held, second dropped.
        ready_cmd = 0;
        conv_n = 4;
        ch_mask = 32'h6;
        enable = 1'b1;
        b = 0;
        while (!s_valid && b < 300) begin @(negedge pll_clk); b++; end
        chk("bp_valid", s_valid, 1);
        chk("bp_chan", s_chan, 1);
        chk("bp_data", s_data, 100);
        b = 0;
        while (!overrun && b < 300) begin @(negedge pll_clk); b++; end
        chk("bp_overrun", overrun, 1);
        chk("bp_hold_chan", s_chan, 1);
        chk("bp_hold_data", s_data, 100);
        enable = 1'b0;
        b = 0;
        while (busy && b < 300) begin @(negedge pll_clk); b++; end
        chk("bp_idle", busy, 0);
        chk("bp_ovr_sticky", overrun, 1);
        clr = 1'b1;
        @(negedge pll_clk);
        clr = 1'b0;
        chk("bp_clr", overrun, 0);
        x0 = n_xfer;
        ready_cmd = 1;
        wait_idle();
        chk("bp_xfers", n_xfer - x0, 1);
        chk("bp_last_chan", last_chan, 1);
        chk("bp_last_data", last_data, 100);

        // Enable dropped during a conversion.
        conv_n = 10;
        ch_mask = 32'hC;
        x0 = n_xfer;
        enable = 1'b1;
        wait_soc_high();
        enable = 1'b0;
        cnt = 0;
        while (adc_soc && cnt < 200) begin
            cnt++;
            @(negedge pll_clk);
        end
        chk("en_drop_soc_held", cnt >= conv_n, 1);
        wait_idle();
        chk("en_drop_xfers", n_xfer - x0, 1);
        chk("en_drop_chan", last_chan, 2);
        chk("en_drop_data", last_data, 200);

        // Reset in the middle of a conversion with a sample pending.
        ready_cmd = 0;
        conv_n = 3;
        ch_mask = 32'h10;
        enable = 1'b1;
        b = 0;
        while (!s_valid && b < 300) begin @(negedge pll_clk); b++; end
        chk("mid_rst_pending", s_valid, 1);
        b = 0;
        while (adc_soc && b < 300) begin @(negedge pll_clk); b++; end
        wait_soc_high();
        rst_n = 1'b0;
        @(negedge pll_clk);
        chk("mid_rst_soc", adc_soc, 0);
        chk("mid_rst_valid", s_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_chsel", adc_chsel, 0);
        chk("mid_rst_tsen", adc_tsen, 0);
        chk("mid_rst_data", s_data, 0);
        chk("mid_rst_chan", s_chan, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_tmo", timeout_err, 0);
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge pll_clk);
        chk("post_rst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
